// File: rtl/xaui_pkg.sv
// Shared definitions for the XAUI receive link controller: FSM states,
// 8b/10b control characters, lane geometry and a small popcount helper.
package xaui_pkg;

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_COMMA     = 3'd2,
        ST_DESKEW    = 3'd3,
        ST_UP        = 3'd4
    } link_state_t;

    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ alignment character
    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma character

    localparam int unsigned NUM_LANES      = 4;
    localparam int unsigned BYTES_PER_LANE = 2;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned LANE_W         = BYTES_PER_LANE * BYTE_W;
    localparam int unsigned MISALIGN_COLS  = 4;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/xaui_a_column_detect.sv
// Combinational /A/ column classifier: per byte position, flags a fully
// aligned column (all lanes /A/) or a partial one (one to three lanes /A/).
module xaui_a_column_detect (
    input  logic [63:0] mgt_rxdata,
    input  logic [7:0]  mgt_rxcharisk,
    output logic [1:0]  aligned,
    output logic [1:0]  partial
);
    import xaui_pkg::*;

    logic [NUM_LANES-1:0] hits;

    always_comb begin
        aligned = '0;
        partial = '0;
        hits    = '0;
        for (int unsigned b = 0; b < BYTES_PER_LANE; b++) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                hits[l] = (mgt_rxdata[l*LANE_W + b*BYTE_W +: BYTE_W] == K28_3)
                          && mgt_rxcharisk[l*BYTES_PER_LANE + b];
            end
            aligned[b] = &hits;
            partial[b] = (|hits) && !(&hits);
        end
    end

endmodule

// File: rtl/xaui_rx_link_ctrl.sv
// XAUI receive link bring-up controller: GTX reset, lock wait, comma
// alignment, lane deskew and link monitoring with statistics counters.
module xaui_rx_link_ctrl #(
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned SYNC_CYCLES = 64,
    parameter int unsigned ALIGN_COLS  = 4,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic        xaui_clk,
    input  logic        reset,
    input  logic [63:0] mgt_rxdata,
    input  logic [7:0]  mgt_rxcharisk,
    input  logic [7:0]  mgt_rxcodevalid,
    input  logic [3:0]  mgt_rxsyncok,
    input  logic [3:0]  mgt_rxlock,
    input  logic [3:0]  mgt_rxbufferr,
    input  logic        clear_counts,
    output logic        mgt_rx_rst,
    output logic [3:0]  mgt_rxencommaalign,
    output logic        mgt_rxenchansync,
    output logic        link_up,
    output logic [2:0]  link_state,
    output logic [15:0] code_err_cnt,
    output logic [7:0]  realign_cnt
);
    import xaui_pkg::*;

    localparam int unsigned RST_W   = $clog2(RST_CYCLES + 1);
    localparam int unsigned SYNC_W  = $clog2(SYNC_CYCLES + 1);
    localparam int unsigned ALIGN_W = $clog2(ALIGN_COLS + 1);
    localparam int unsigned MIS_W   = $clog2(MISALIGN_COLS + 1);

    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [SYNC_W-1:0]  SYNC_LAST  = SYNC_W'(SYNC_CYCLES - 1);
    localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_COLS - 1);
    localparam logic [MIS_W-1:0]   MIS_LAST   = MIS_W'(MISALIGN_COLS - 1);

    link_state_t          state, next_state;
    logic [RST_W-1:0]     rst_cnt;
    logic [SYNC_W-1:0]    sync_cnt;
    logic [ALIGN_W-1:0]   align_cnt;
    logic [MIS_W-1:0]     mis_cnt;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [1:0]           col_aligned, col_partial;
    logic                 any_aligned, any_partial, sync_all, lock_all;
    logic                 fatal, timeout, state_change;
    logic [16:0]          err_sum;

    xaui_a_column_detect u_col (
        .mgt_rxdata    (mgt_rxdata),
        .mgt_rxcharisk (mgt_rxcharisk),
        .aligned       (col_aligned),
        .partial       (col_partial)
    );

    always_comb begin
        any_aligned = |col_aligned;
        any_partial = |col_partial;
        sync_all    = (mgt_rxsyncok == 4'hF);
        lock_all    = (mgt_rxlock == 4'hF);

        // Missing lock is the normal condition in WAIT_LOCK, so it is only fatal afterwards.
        fatal = 1'b0;
        if (state != ST_RST) begin
            fatal = (mgt_rxbufferr != 4'h0)
                 || (!lock_all && state != ST_WAIT_LOCK)
                 || (!sync_all && (state == ST_DESKEW || state == ST_UP));
        end
        timeout = (state == ST_COMMA || state == ST_DESKEW) && (to_cnt == '1);

        next_state = state;
        case (state)
            ST_RST:       if (rst_cnt == RST_LAST) next_state = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_all) next_state = ST_COMMA;
            ST_COMMA:     if (sync_all && sync_cnt == SYNC_LAST) next_state = ST_DESKEW;
            ST_DESKEW:    if (any_aligned && !any_partial && align_cnt == ALIGN_LAST)
                              next_state = ST_UP;
            ST_UP:        if (any_partial && mis_cnt == MIS_LAST) next_state = ST_DESKEW;
            default:      next_state = ST_RST;
        endcase
        if (fatal || timeout) next_state = ST_RST;

        state_change = (next_state != state);
        err_sum      = {1'b0, code_err_cnt} + 17'(popcount8(~mgt_rxcodevalid));
    end

    always_ff @(posedge xaui_clk) begin
        if (reset) begin
            state              <= ST_RST;
            rst_cnt            <= '0;
            sync_cnt           <= '0;
            align_cnt          <= '0;
            mis_cnt            <= '0;
            to_cnt             <= '0;
            mgt_rx_rst         <= 1'b1;
            mgt_rxencommaalign <= '0;
            mgt_rxenchansync   <= 1'b0;
            link_up            <= 1'b0;
            code_err_cnt       <= '0;
            realign_cnt        <= '0;
        end else begin
            state    <= next_state;
            rst_cnt  <= (state == ST_RST && !state_change) ? rst_cnt + 1'b1 : '0;
            sync_cnt <= (state == ST_COMMA && !state_change && sync_all) ? sync_cnt + 1'b1 : '0;
            to_cnt   <= ((state == ST_COMMA || state == ST_DESKEW) && !state_change)
                        ? to_cnt + 1'b1 : '0;

            // A partial column in the same cycle as an aligned one counts as partial.
            if (state != ST_DESKEW || state_change || any_partial) align_cnt <= '0;
            else if (any_aligned)                                   align_cnt <= align_cnt + 1'b1;

            if (state != ST_UP || state_change) mis_cnt <= '0;
            else if (any_partial)               mis_cnt <= mis_cnt + 1'b1;
            else if (any_aligned)               mis_cnt <= '0;

            if (clear_counts) realign_cnt <= '0;
            else if (state == ST_UP && next_state == ST_DESKEW && realign_cnt != '1)
                realign_cnt <= realign_cnt + 1'b1;

            if (clear_counts)       code_err_cnt <= '0;
            else if (state == ST_UP) code_err_cnt <= err_sum[16] ? '1 : err_sum[15:0];

            mgt_rx_rst         <= (state == ST_RST);
            link_up            <= (state == ST_UP);
            mgt_rxencommaalign <= {4{state inside {ST_COMMA, ST_DESKEW, ST_UP}}};
            mgt_rxenchansync   <= (state == ST_DESKEW || state == ST_UP);
        end
    end

    assign link_state = state;

endmodule

// File: tb/tb_xaui_rx_link_ctrl.sv
// Directed, table-driven bench for xaui_rx_link_ctrl: bring-up, realign,
// lock loss, counter saturation, sync glitch, lane-skew timeout, buffer error.
module tb_xaui_rx_link_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] rxdata;
    logic [7:0]  charisk;
    logic [7:0]  codevalid;
    logic [3:0]  syncok;
    logic [3:0]  lock;
    logic [3:0]  bufferr;
    logic        clear_counts;
    logic        mgt_rx_rst;
    logic [3:0]  mgt_rxencommaalign;
    logic        mgt_rxenchansync;
    logic        link_up;
    logic [2:0]  link_state;
    logic [15:0] code_err_cnt;
    logic [7:0]  realign_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xaui_rx_link_ctrl #(
        .RST_CYCLES  (16),
        .SYNC_CYCLES (64),
        .ALIGN_COLS  (4),
        .TIMEOUT_W   (16)
    ) dut (
        .xaui_clk           (clk),
        .reset              (reset),
        .mgt_rxdata         (rxdata),
        .mgt_rxcharisk      (charisk),
        .mgt_rxcodevalid    (codevalid),
        .mgt_rxsyncok       (syncok),
        .mgt_rxlock         (lock),
        .mgt_rxbufferr      (bufferr),
        .clear_counts       (clear_counts),
        .mgt_rx_rst         (mgt_rx_rst),
        .mgt_rxencommaalign (mgt_rxencommaalign),
        .mgt_rxenchansync   (mgt_rxenchansync),
        .link_up            (link_up),
        .link_state         (link_state),
        .code_err_cnt       (code_err_cnt),
        .realign_cnt        (realign_cnt)
    );

    typedef struct {
        logic [3:0] amask;   // lanes carrying 0x7C at pos
        logic [3:0] kmask;   // charisk for those bytes
        int         pos;
        logic [2:0] st;
        logic       up;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl [18];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle;
        rxdata  = {32{8'hBC}};
        charisk = 8'hFF;
    endtask

    task automatic set_col(input logic [3:0] amask, input logic [3:0] kmask, input int pos);
        set_idle();
        for (int l = 0; l < 4; l++) begin
            if (amask[l]) begin
                rxdata[l*16 + pos*8 +: 8] = 8'h7C;
                charisk[l*2 + pos]        = kmask[l];
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int limit, output int n);
        n = 0;
        while (link_state != target && n < limit) begin
            tick();
            n++;
        end
    endtask

    int comma_cyc, deskew_cyc, up_cyc, lu_cyc, rst_high, n, found, deskew_n;
    logic [3:0] ca20, ca21;
    logic       cs84, cs85;

    initial begin
        tbl[0]  = '{4'b0111, 4'hF,    0, 3'd4, 1'b1, 8'd0};
        tbl[1]  = '{4'b1011, 4'hF,    1, 3'd4, 1'b1, 8'd0};
        tbl[2]  = '{4'b0001, 4'hF,    0, 3'd4, 1'b1, 8'd0};
        tbl[3]  = '{4'b1111, 4'hF,    1, 3'd4, 1'b1, 8'd0};
        tbl[4]  = '{4'b1110, 4'hF,    0, 3'd4, 1'b1, 8'd0};
        tbl[5]  = '{4'b1111, 4'b1101, 0, 3'd4, 1'b1, 8'd0};
        tbl[6]  = '{4'b0000, 4'hF,    0, 3'd4, 1'b1, 8'd0};
        tbl[7]  = '{4'b0100, 4'hF,    1, 3'd4, 1'b1, 8'd0};
        tbl[8]  = '{4'b0000, 4'hF,    0, 3'd4, 1'b1, 8'd0};
        tbl[9]  = '{4'b1000, 4'hF,    0, 3'd3, 1'b1, 8'd1};
        tbl[10] = '{4'b1111, 4'hF,    0, 3'd3, 1'b0, 8'd1};
        tbl[11] = '{4'b0011, 4'hF,    1, 3'd3, 1'b0, 8'd1};
        tbl[12] = '{4'b1111, 4'hF,    1, 3'd3, 1'b0, 8'd1};
        tbl[13] = '{4'b1111, 4'hF,    0, 3'd3, 1'b0, 8'd1};
        tbl[14] = '{4'b0000, 4'hF,    0, 3'd3, 1'b0, 8'd1};
        tbl[15] = '{4'b1111, 4'hF,    0, 3'd3, 1'b0, 8'd1};
        tbl[16] = '{4'b1111, 4'hF,    1, 3'd4, 1'b0, 8'd1};
        tbl[17] = '{4'b0000, 4'hF,    0, 3'd4, 1'b1, 8'd1};

        reset        = 1'b1;
        set_idle();
        codevalid    = 8'hFF;
        syncok       = 4'hF;
        lock         = 4'h0;
        bufferr      = 4'h0;
        clear_counts = 1'b0;
        repeat (3) tick();

        check("rst_state",      link_state, 3'd0);
        check("rst_mgt_rx_rst", mgt_rx_rst, 1'b1);
        check("rst_link_up",    link_up, 1'b0);
        check("rst_commaalign", mgt_rxencommaalign, 4'h0);
        check("rst_chansync",   mgt_rxenchansync, 1'b0);
        check("rst_code_err",   code_err_cnt, 16'h0);
        check("rst_realign",    realign_cnt, 8'h0);

        // Bring-up: lock at cycle 20, aligned /A/ every 8 cycles
        reset = 1'b0;
        comma_cyc = 0; deskew_cyc = 0; up_cyc = 0; lu_cyc = 0; rst_high = 0;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            lock = (cyc >= 20) ? 4'hF : 4'h0;
            if (cyc % 8 == 0) set_col(4'hF, 4'hF, 0);
            else              set_idle();
            tick();
            if (mgt_rx_rst) rst_high++;
            if (link_state == 3'd2 && comma_cyc == 0)  comma_cyc  = cyc;
            if (link_state == 3'd3 && deskew_cyc == 0) deskew_cyc = cyc;
            if (link_state == 3'd4 && up_cyc == 0)     up_cyc     = cyc;
            if (link_up && lu_cyc == 0)                lu_cyc     = cyc;
            if (cyc == 20) ca20 = mgt_rxencommaalign;
            if (cyc == 21) ca21 = mgt_rxencommaalign;
            if (cyc == 84) cs84 = mgt_rxenchansync;
            if (cyc == 85) cs85 = mgt_rxenchansync;
        end
        set_idle();
        check("bringup_rst_cycles",  rst_high, 16);
        check("bringup_comma_cyc",   comma_cyc, 20);
        check("bringup_comma_out0",  ca20, 4'h0);
        check("bringup_comma_out1",  ca21, 4'hF);
        check("bringup_deskew_cyc",  deskew_cyc, 84);
        check("bringup_chansync0",   cs84, 1'b0);
        check("bringup_chansync1",   cs85, 1'b1);
        check("bringup_up_cyc",      up_cyc, 112);
        check("bringup_link_up_cyc", lu_cyc, 113);

        // Realign behaviour in UP, then re-deskew
        for (int i = 0; i < 18; i++) begin
            set_col(tbl[i].amask, tbl[i].kmask, tbl[i].pos);
            tick();
            check($sformatf("tbl%0d_state", i),   link_state,  tbl[i].st);
            check($sformatf("tbl%0d_link_up", i), link_up,     tbl[i].up);
            check($sformatf("tbl%0d_realign", i), realign_cnt, tbl[i].rc);
        end
        set_idle();

        // Lock loss in UP
        lock = 4'b1101;
        tick();
        check("lockloss_state", link_state, 3'd0);
        check("lockloss_link_up_hold", link_up, 1'b1);
        lock = 4'hF;
        tick();
        check("lockloss_link_up", link_up, 1'b0);
        check("lockloss_rx_rst",  mgt_rx_rst, 1'b1);
        check("lockloss_realign", realign_cnt, 8'd1);

        set_col(4'hF, 4'hF, 0);
        wait_state(3'd4, 500, n);
        check("rebringup_up", link_state, 3'd4);
        set_idle();
        tick();

        // Code error saturation and clear
        codevalid = 8'h00;
        tick();
        check("codeerr_first", code_err_cnt, 16'd8);
        repeat (8999) tick();
        check("codeerr_sat",   code_err_cnt, 16'hFFFF);
        check("codeerr_state", link_state, 3'd4);
        clear_counts = 1'b1;
        tick();
        check("codeerr_clear", code_err_cnt, 16'h0);
        check("realign_clear", realign_cnt, 8'h0);
        clear_counts = 1'b0;
        tick();
        check("codeerr_after_clear", code_err_cnt, 16'd8);
        codevalid = 8'hA5;
        tick();
        check("codeerr_partial", code_err_cnt, 16'd12);
        codevalid = 8'hFF;

        // Reset mid-operation from UP
        reset = 1'b1;
        tick();
        check("midrst_state",    link_state, 3'd0);
        check("midrst_link_up",  link_up, 1'b0);
        check("midrst_code_err", code_err_cnt, 16'h0);
        check("midrst_rx_rst",   mgt_rx_rst, 1'b1);
        tick();
        reset = 1'b0;
        n = 0; rst_high = 0;
        while (link_state != 3'd2 && n < 100) begin
            tick();
            n++;
            if (mgt_rx_rst) rst_high++;
        end
        check("midrst_comma_cyc",  n, 17);
        check("midrst_rst_cycles", rst_high, 16);

        // Sync glitch in COMMA at count 63
        repeat (63) tick();
        check("glitch_pre_state", link_state, 3'd2);
        syncok = 4'h7;
        tick();
        check("glitch_state", link_state, 3'd2);
        syncok = 4'hF;
        found = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (link_state == 3'd3) begin
                found = i;
                break;
            end
        end
        check("glitch_deskew_cyc", found, 64);

        // Lane 2 /A/ one cycle late: never aligned, DESKEW times out
        deskew_n = 1;
        for (int k = 0; k < 70000; k++) begin
            if (k % 8 == 0)      set_col(4'b1011, 4'hF, 0);
            else if (k % 8 == 1) set_col(4'b0100, 4'hF, 0);
            else                 set_idle();
            tick();
            if (link_state == 3'd3) deskew_n++;
            else break;
        end
        set_idle();
        check("skew_deskew_len", deskew_n, 65536);
        check("skew_state",      link_state, 3'd0);
        tick();
        check("skew_rx_rst",     mgt_rx_rst, 1'b1);

        // Elastic-buffer error in COMMA
        wait_state(3'd2, 100, n);
        check("buferr_pre_state", link_state, 3'd2);
        bufferr = 4'b0100;
        tick();
        check("buferr_state", link_state, 3'd0);
        bufferr = 4'h0;
        tick();
        check("buferr_rx_rst", mgt_rx_rst, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
